// File: rtl/pong_ball_engine.sv
// -----------------------------------------------------------------------------
// pong_ball_engine
//
// Purpose:
//   Moves a square ball across the screen and runs the serve, play and scored
//   sequence of a Pong game. The ball bounces off the top and bottom walls and
//   off the left and right paddles. A point is scored when the ball passes a
//   paddle. Each player's score saturates at 15. The ball box outputs drive the
//   pixel renderer.
//
// Ports:
//   i_clk, i_rst            clock; synchronous active-high reset
//   i_ani_stb, i_animate    animation strobe and its qualifier (step = both high)
//   i_lpad_y1/y2            left paddle top/bottom rows (inclusive)
//   i_rpad_y1/y2            right paddle top/bottom rows (inclusive)
//   o_x1/o_x2, o_y1/o_y2    ball box edges (centre -/+ H_SIZE)
//   o_hit                   1-cycle pulse on a paddle bounce
//   o_point_l/o_point_r     1-cycle pulse when the left/right player scores
//   o_score_l/o_score_r     player scores, saturating at 15
//   o_state                 0=SERVE 1=PLAY 2=SCORED
//
// Configuration:
//   PONG_BALL_SPEEDUP_EN    when defined, each paddle hit raises the ball speed
//                           by 1 up to MAX_SPEED; the speed resets on every serve.
//                           When undefined, the speed is the constant SPEED.
// -----------------------------------------------------------------------------
module pong_ball_engine #(
  parameter int H_SIZE     = 8,
  parameter int IX         = 320,
  parameter int IY         = 240,
  parameter int IX_DIR     = 1,
  parameter int IY_DIR     = 1,
  parameter int D_WIDTH    = 640,
  parameter int D_HEIGHT   = 480,
  parameter int PAD_X_L    = 32,
  parameter int PAD_X_R    = 608,
  parameter int SPEED      = 2,
  parameter int MAX_SPEED  = 6,
  parameter int SERVE_WAIT = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic [11:0] i_lpad_y1,
  input  logic [11:0] i_lpad_y2,
  input  logic [11:0] i_rpad_y1,
  input  logic [11:0] i_rpad_y2,
  output logic [11:0] o_x1,
  output logic [11:0] o_x2,
  output logic [11:0] o_y1,
  output logic [11:0] o_y2,
  output logic        o_hit,
  output logic        o_point_l,
  output logic        o_point_r,
  output logic [3:0]  o_score_l,
  output logic [3:0]  o_score_r,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2
  } state_t;

  localparam int CNT_W = (SERVE_WAIT > 1) ? $clog2(SERVE_WAIT) : 1;

  // Bounds, all in 13 bits so that no sum or difference can wrap.
  localparam logic [12:0] H13      = 13'(H_SIZE);
  localparam logic [12:0] Y_MAX    = 13'(D_HEIGHT - 1 - H_SIZE);
  localparam logic [12:0] X_GOAL_R = 13'(D_WIDTH - 1 - H_SIZE);
  localparam logic [12:0] L_FACE   = 13'(PAD_X_L + H_SIZE);
  localparam logic [12:0] R_FACE   = 13'(PAD_X_R);
  localparam logic [11:0] L_CLAMP  = 12'(PAD_X_L + H_SIZE + 1);
  localparam logic [11:0] R_CLAMP  = 12'(PAD_X_R - H_SIZE - 1);

  // A serve speed above the ceiling is a configuration error.
  if (SPEED < 1 || SPEED > MAX_SPEED) begin : g_bad_speed
    $error("pong_ball_engine: SPEED must lie in 1..MAX_SPEED");
  end

  function automatic logic [3:0] sat_inc_score(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  state_t             state_q;
  logic [11:0]        x_q, y_q;
  logic               x_dir_q, y_dir_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               tog_q;
  logic [3:0]         score_l_q, score_r_q;
  logic               hit_q, point_l_q, point_r_q;

  logic [12:0]        spd13;

`ifdef PONG_BALL_SPEEDUP_EN
  localparam logic [3:0] SPD_MAX = 4'(MAX_SPEED);
  logic [3:0] spd_q;

  function automatic logic [3:0] sat_inc_speed(input logic [3:0] s);
    return (s >= SPD_MAX) ? SPD_MAX : s + 4'd1;
  endfunction

  assign spd13 = {9'd0, spd_q};
`else
  assign spd13 = 13'(SPEED);
`endif

  logic        step;
  logic [12:0] x13, y13, nx, ny;
  logic [11:0] y_d;
  logic        y_dir_d;
  logic        l_hit, r_hit, l_goal, r_goal;

  always_comb begin
    step = i_animate & i_ani_stb;
    x13  = {1'b0, x_q};
    y13  = {1'b0, y_q};
    nx   = x_dir_q ? x13 + spd13 : x13 - spd13;
    ny   = y_dir_q ? y13 + spd13 : y13 - spd13;

    // Wall bounce clamps onto the wall and reverses vertical direction.
    y_d     = ny[11:0];
    y_dir_d = y_dir_q;
    if (y_dir_q) begin
      if (ny >= Y_MAX) begin
        y_d     = Y_MAX[11:0];
        y_dir_d = 1'b0;
      end
    end else if (ny <= H13) begin
      y_d     = H13[11:0];
      y_dir_d = 1'b1;
    end

    // A hit needs the ball edge to cross the paddle face on this step; a ball
    // that is already past the face can only go on to score. The comparisons
    // are rearranged to add H_SIZE on the other side instead of subtracting.
    l_hit  = !x_dir_q && (nx <= L_FACE) && (x13 > L_FACE) &&
             (y13 + H13 >= {1'b0, i_lpad_y1}) && (y13 <= {1'b0, i_lpad_y2} + H13);
    r_hit  =  x_dir_q && (nx + H13 >= R_FACE) && (x13 + H13 < R_FACE) &&
             (y13 + H13 >= {1'b0, i_rpad_y1}) && (y13 <= {1'b0, i_rpad_y2} + H13);
    l_goal = !x_dir_q && !l_hit && (nx <= H13);
    r_goal =  x_dir_q && !r_hit && (nx >= X_GOAL_R);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= SERVE;
      x_q       <= 12'(IX);
      y_q       <= 12'(IY);
      x_dir_q   <= (IX_DIR != 0);
      y_dir_q   <= (IY_DIR != 0);
      cnt_q     <= '0;
      tog_q     <= 1'b0;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      hit_q     <= 1'b0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
      spd_q     <= 4'(SPEED);
`endif
    end else begin
      hit_q     <= 1'b0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
      case (state_q)
        SERVE: begin
          if (step) begin
            if (cnt_q == CNT_W'(SERVE_WAIT - 1)) begin
              state_q <= PLAY;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        PLAY: begin
          if (step) begin
            // A goal freezes the ball for its last cycle; position is reset in SCORED.
            if (l_goal) begin
              point_r_q <= 1'b1;
              score_r_q <= sat_inc_score(score_r_q);
              state_q   <= SCORED;
            end else if (r_goal) begin
              point_l_q <= 1'b1;
              score_l_q <= sat_inc_score(score_l_q);
              state_q   <= SCORED;
            end else begin
              y_q     <= y_d;
              y_dir_q <= y_dir_d;
              if (l_hit || r_hit) begin
                x_q     <= l_hit ? L_CLAMP : R_CLAMP;
                x_dir_q <= l_hit;
                hit_q   <= 1'b1;
`ifdef PONG_BALL_SPEEDUP_EN
                spd_q   <= sat_inc_speed(spd_q);
`endif
              end else begin
                x_q <= nx[11:0];
              end
            end
          end
        end
        SCORED: begin
          // The toggle flips on every goal and the new value picks the serve
          // direction, so consecutive serves go opposite ways starting from
          // IX_DIR after reset.
          x_q     <= 12'(IX);
          y_q     <= 12'(IY);
          y_dir_q <= (IY_DIR != 0);
          x_dir_q <= (IX_DIR != 0) ^ ~tog_q;
          tog_q   <= ~tog_q;
          cnt_q   <= '0;
          state_q <= SERVE;
`ifdef PONG_BALL_SPEEDUP_EN
          spd_q   <= 4'(SPEED);
`endif
        end
        default: state_q <= SERVE;
      endcase
    end
  end

  assign o_x1      = x_q - 12'(H_SIZE);
  assign o_x2      = x_q + 12'(H_SIZE);
  assign o_y1      = y_q - 12'(H_SIZE);
  assign o_y2      = y_q + 12'(H_SIZE);
  assign o_hit     = hit_q;
  assign o_point_l = point_l_q;
  assign o_point_r = point_r_q;
  assign o_score_l = score_l_q;
  assign o_score_r = score_r_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Testbench for pong_ball_engine: directed scenarios with constant expectations,
// then randomized play checked against a behavioural game model.
module tb_pong_ball_engine;
  localparam int H = 8, IX = 320, IY = 240, IXD = 1, IYD = 1;
  localparam int DW = 640, DH = 480, PXL = 32, PXR = 608;
  localparam int SPEED = 2, MAXS = 6, SW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stb = 1'b0, anim = 1'b0;
  logic [11:0] lp1 = '0, lp2 = '0, rp1 = '0, rp2 = '0;
  logic [11:0] x1, x2, y1, y2;
  logic        hit, pl, pr;
  logic [3:0]  sl, sr;
  logic [1:0]  st;

  always #5 clk = ~clk;

  pong_ball_engine #(.SERVE_WAIT(SW)) dut (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_animate(anim),
    .i_lpad_y1(lp1), .i_lpad_y2(lp2), .i_rpad_y1(rp1), .i_rpad_y2(rp2),
    .o_x1(x1), .o_x2(x2), .o_y1(y1), .o_y2(y2),
    .o_hit(hit), .o_point_l(pl), .o_point_r(pr),
    .o_score_l(sl), .o_score_r(sr), .o_state(st)
  );

  int checks = 0, errors = 0;

  // Game model: ball centre, direction (+1/-1), speed, phase, scores.
  int mx, my, mdx, mdy, mspd, mcnt, mphase, msl, msr;
  bit mnext_left;  // direction of the next serve after a goal
  bit mhit, mpl, mpr;

  task automatic model_edge(input bit r, input bit step, input int l1, l2, q1, q2);
    int nx, ny;
    bit lh, rh;
    mhit = 0; mpl = 0; mpr = 0;
    if (r) begin
      mx = IX; my = IY; mdx = IXD ? 1 : -1; mdy = IYD ? 1 : -1;
      mspd = SPEED; mcnt = 0; mphase = 0; msl = 0; msr = 0;
      mnext_left = IXD ? 1 : 0;
    end else if (mphase == 2) begin
      mx = IX; my = IY; mdy = IYD ? 1 : -1; mspd = SPEED;
      mdx = mnext_left ? -1 : 1;
      mnext_left = !mnext_left;
      mphase = 0; mcnt = 0;
    end else if (mphase == 0) begin
      if (step) begin
        mcnt++;
        if (mcnt == SW) begin mphase = 1; mcnt = 0; end
      end
    end else if (step) begin
      nx = mx + mdx * mspd;
      ny = my + mdy * mspd;
      lh = (mdx < 0) && (nx - H <= PXL) && (mx - H > PXL) && (my + H >= l1) && (my - H <= l2);
      rh = (mdx > 0) && (nx + H >= PXR) && (mx + H < PXR) && (my + H >= q1) && (my - H <= q2);
      if (mdx < 0 && !lh && nx <= H) begin
        mpr = 1; msr = (msr < 15) ? msr + 1 : 15; mphase = 2;
      end else if (mdx > 0 && !rh && nx >= DW - 1 - H) begin
        mpl = 1; msl = (msl < 15) ? msl + 1 : 15; mphase = 2;
      end else begin
        if (mdy > 0 && ny >= DH - 1 - H) begin my = DH - 1 - H; mdy = -1; end
        else if (mdy < 0 && ny <= H) begin my = H; mdy = 1; end
        else my = ny;
        if (lh) begin mx = PXL + H + 1; mdx = 1; end
        else if (rh) begin mx = PXR - H - 1; mdx = -1; end
        else mx = nx;
        if (lh || rh) begin
          mhit = 1;
`ifdef PONG_BALL_SPEEDUP_EN
          mspd = (mspd + 1 > MAXS) ? MAXS : mspd + 1;
`endif
        end
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic tick(input bit r, input bit s, input bit a, input int l1, l2, q1, q2);
    rst = r; stb = s; anim = a;
    lp1 = 12'(l1); lp2 = 12'(l2); rp1 = 12'(q1); rp2 = 12'(q2);
    @(posedge clk);
    model_edge(r, s && a, l1, l2, q1, q2);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 479, 0, 479);
    checks++; if (x1 !== 12'd312) begin errors++; $display("FAIL reset_x1: got %0d want 312", x1); end
    checks++; if (x2 !== 12'd328) begin errors++; $display("FAIL reset_x2: got %0d want 328", x2); end
    checks++; if (y1 !== 12'd232) begin errors++; $display("FAIL reset_y1: got %0d want 232", y1); end
    checks++; if (y2 !== 12'd248) begin errors++; $display("FAIL reset_y2: got %0d want 248", y2); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", st); end
    checks++; if ({sl, sr} !== 8'd0) begin errors++; $display("FAIL reset_scores: got %0d/%0d want 0/0", sl, sr); end
    checks++; if ({hit, pl, pr} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {hit, pl, pr}); end
  endtask

  task automatic test_serve();
    tick(0, 1, 0, 0, 479, 0, 479);  // qualifier low: not a step
    for (int i = 0; i < SW - 1; i++) tick(0, 1, 1, 0, 479, 0, 479);
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL serve_wait: got state %0d want 0", st); end
    tick(0, 1, 1, 0, 479, 0, 479);
    checks++; if (st !== 2'd1) begin errors++; $display("FAIL serve_to_play: got state %0d want 1", st); end
    checks++; if (x1 !== 12'd312) begin errors++; $display("FAIL serve_hold: got x1 %0d want 312", x1); end
    tick(0, 1, 1, 0, 479, 0, 479);
    checks++; if ({x1, y1} !== {12'd314, 12'd234}) begin errors++; $display("FAIL first_move: got x1=%0d y1=%0d want 314/234", x1, y1); end
    tick(0, 1, 0, 0, 479, 0, 479);
    checks++; if ({x1, y1} !== {12'd314, 12'd234}) begin errors++; $display("FAIL freeze: got x1=%0d y1=%0d want 314/234", x1, y1); end
  endtask

  task automatic test_right_hit();
    bit seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick(0, 1, 1, 0, 479, 0, 479);
      seen = hit;
    end
    checks++; if (!seen) begin errors++; $display("FAIL hit_timeout: got no o_hit want o_hit within 1000 cycles"); end
    checks++; if ({x1, x2} !== {12'd591, 12'd607}) begin errors++; $display("FAIL hit_clamp: got x1=%0d x2=%0d want 591/607", x1, x2); end
    tick(0, 0, 1, 0, 479, 0, 479);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_width: got o_hit %b want 0", hit); end
    tick(0, 1, 1, 0, 479, 0, 479);
`ifdef PONG_BALL_SPEEDUP_EN
    checks++; if (x1 !== 12'd588) begin errors++; $display("FAIL hit_rebound: got x1 %0d want 588", x1); end
`else
    checks++; if (x1 !== 12'd589) begin errors++; $display("FAIL hit_rebound: got x1 %0d want 589", x1); end
`endif
  endtask

  task automatic test_goal();
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick(0, 1, 1, 0, 479, 4000, 4000);
      seen = pl;
    end
    checks++; if (!seen) begin errors++; $display("FAIL goal_timeout: got no o_point_l want one within 2000 cycles"); end
    checks++; if ({sl, sr, st} !== {4'd1, 4'd0, 2'd2}) begin errors++; $display("FAIL goal_score: got sl=%0d sr=%0d st=%0d want 1/0/2", sl, sr, st); end
    tick(0, 0, 1, 0, 479, 4000, 4000);
    checks++; if ({pl, st} !== {1'b0, 2'd0}) begin errors++; $display("FAIL goal_after: got pl=%b st=%0d want 0/0", pl, st); end
    checks++; if ({x1, y1} !== {12'd312, 12'd232}) begin errors++; $display("FAIL goal_recentre: got x1=%0d y1=%0d want 312/232", x1, y1); end
    for (int i = 0; i < SW + 1; i++) tick(0, 1, 1, 0, 479, 4000, 4000);
    checks++; if ({x1, y1} !== {12'd310, 12'd234}) begin errors++; $display("FAIL serve_flip: got x1=%0d y1=%0d want 310/234", x1, y1); end
  endtask

  task automatic test_saturation();
    bit seen = 0;
    for (int i = 0; i < 20000 && sl != 4'd15; i++) tick(0, 1, 1, 0, 479, 4000, 4000);
    checks++; if (sl !== 4'd15) begin errors++; $display("FAIL sat_reach: got score_l %0d want 15", sl); end
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick(0, 1, 1, 0, 479, 4000, 4000);
      seen = pl;
    end
    checks++; if ({seen, sl} !== {1'b1, 4'd15}) begin errors++; $display("FAIL sat_hold: got point=%b score_l=%0d want 1/15", seen, sl); end
    tick(1, 1, 1, 0, 479, 4000, 4000);  // mid-operation reset
    checks++; if ({x1, y1, st, sl, sr, hit, pl, pr} !== {12'd312, 12'd232, 2'd0, 4'd0, 4'd0, 3'b000}) begin
      errors++; $display("FAIL mid_reset: got x1=%0d y1=%0d st=%0d sl=%0d sr=%0d pulses=%b want 312/232/0/0/0/000",
                         x1, y1, st, sl, sr, {hit, pl, pr});
    end
  endtask

  task automatic test_random();
    int a = 0, b = 479, c = 0, d = 479;
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) begin
        a = $urandom_range(0, 400); b = a + $urandom_range(10, 200);
        c = $urandom_range(0, 400); d = c + $urandom_range(10, 200);
      end
      tick($urandom_range(0, 1499) == 0, $urandom_range(0, 1), $urandom_range(0, 9) != 0, a, b, c, d);
      checks++;
      if ({x1, x2, y1, y2} !== {12'(mx - H), 12'(mx + H), 12'(my - H), 12'(my + H)}) begin
        errors++; $display("FAIL rnd_box cyc %0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                           i, x1, x2, y1, y2, mx - H, mx + H, my - H, my + H);
      end
      checks++;
      if ({hit, pl, pr} !== {mhit, mpl, mpr}) begin
        errors++; $display("FAIL rnd_pulses cyc %0d: got %b want %b", i, {hit, pl, pr}, {mhit, mpl, mpr});
      end
      checks++;
      if ({st, sl, sr} !== {2'(mphase), 4'(msl), 4'(msr)}) begin
        errors++; $display("FAIL rnd_state cyc %0d: got st=%0d sl=%0d sr=%0d want %0d/%0d/%0d",
                           i, st, sl, sr, mphase, msl, msr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_right_hit();
    test_goal();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
